mem_arbiter: RTL and testbench



---
 rtl/mem_pkg.sv | 17 +
 rtl/rr_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the unified memory arbiter
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_LOAD  = 2;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner, searching upward from last_i+1
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [IW-1:0]   win_o,
  output logic            valid_o
);

  always_comb begin
    logic [IW-1:0] cand;
    cand    = '0;
    win_o   = '0;
    valid_o = 1'b0;
    // k = NREQ wraps to last_i itself, so a lone re-requester still wins
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_i) + k) % NREQ);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        win_o   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one handshaked memory port, with watchdog abort
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int NREQ    = REQ_LOAD + 1,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic [NREQ-1:0]  err,
  output logic [DW-1:0]    rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic             mem_ack,
  input  logic [DW-1:0]    mem_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [AW-1:0] addr_a  [NREQ];
  logic [DW-1:0] wdata_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_a[g]  = addr[g*AW +: AW];
    assign wdata_a[g] = wdata[g*DW +: DW];
  end

  state_e          state_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   rr_last_q;
  logic [7:0]      wd_q;
  logic [7:0]      wd_d;
  logic [NREQ-1:0] gnt_q, done_q, err_q;
  logic [DW-1:0]   rdata_q;
  logic            mem_req_q, mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
    .req_i   (req),
    .last_i  (rr_last_q),
    .win_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign wd_d = wd_q + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_last_q   <= IW'(NREQ - 1);
      wd_q        <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            owner_q           <= pick_idx;
            rr_last_q         <= pick_idx;
            mem_we_q          <= we[pick_idx];
            mem_addr_q        <= addr_a[pick_idx];
            mem_wdata_q       <= wdata_a[pick_idx];
            mem_req_q         <= 1'b1;
            gnt_q[pick_idx]   <= 1'b1;
            wd_q              <= '0;
            state_q           <= BUSY;
          end
        end
        BUSY: begin
          // ack is checked first so a same-cycle ack beats the watchdog
          if (mem_ack) begin
            if (!mem_we_q) begin
              rdata_q <= mem_rdata;
            end
            mem_req_q       <= 1'b0;
            done_q[owner_q] <= 1'b1;
            state_q         <= DONE;
          end else if (wd_d == 8'(TIMEOUT)) begin
            mem_req_q      <= 1'b0;
            err_q[owner_q] <= 1'b1;
            wd_q           <= wd_d;
            state_q        <= DONE;
          end else begin
            wd_q <= wd_d;
          end
        end
        DONE: begin
          wd_q    <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a delay-programmable memory model
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = '0;
  logic [2:0]  we_v = '0;
  logic [47:0] addr_v = '0;
  logic [47:0] wdata_v = '0;
  logic [2:0]  gnt, done, err;
  logic [15:0] rdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;

  mem_arbiter #(.NREQ(3), .AW(16), .DW(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we_v), .addr(addr_v), .wdata(wdata_v),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          delay;
    logic [15:0] mrd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    int          idx;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        is_err;
    int          lat;
  } sb_t;

  sb_t         sb[$];
  int          gnt_log[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          ack_delay = 255;
  logic        stray = 1'b0;
  logic [15:0] mrd_val = '0;
  logic [15:0] model_rdata = '0;
  logic        mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Memory model: acks ack_delay cycles into an access, or on a forced stray pulse.
  initial begin
    int bcnt;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        mem_ack = (bcnt == ack_delay) || stray;
        bcnt++;
      end else begin
        bcnt    = 0;
        mem_ack = stray;
      end
      mem_rdata = mrd_val;
    end
  end

  // Monitor: checks grants, latched memory signals and completions against the scoreboard.
  initial begin
    int  gcyc;
    int  busy;
    sb_t e;
    gcyc = 0;
    busy = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("onehot_pulses", 32'($countones({gnt, done, err}) <= 1), 32'd1);
        if (gnt != 0) begin
          if (sb.size() == 0) fail_now("unexpected_gnt");
          else begin
            chk("gnt_owner", 32'(gnt), 32'(1 << sb[0].idx));
            gcyc = cyc;
            busy = 0;
            gnt_log.push_back(cyc);
          end
        end
        if (mem_req && sb.size() > 0) begin
          busy++;
          chk("mem_addr", 32'(mem_addr), 32'(sb[0].addr));
          chk("mem_we", 32'(mem_we), 32'(sb[0].we));
          if (sb[0].we) chk("mem_wdata", 32'(mem_wdata), 32'(sb[0].wdata));
        end
        if ((done | err) != 0) begin
          if (sb.size() == 0) fail_now("unexpected_completion");
          else begin
            e = sb.pop_front();
            chk("done_vec", 32'(done), e.is_err ? 32'd0 : 32'(1 << e.idx));
            chk("err_vec", 32'(err), e.is_err ? 32'(1 << e.idx) : 32'd0);
            chk("rdata", 32'(rdata), 32'(e.rdata));
            chk("latency", 32'(cyc - gcyc), 32'(e.lat));
            chk("busy_cycles", 32'(busy), 32'(e.lat));
          end
        end
      end
    end
  end

  task automatic drain(input int bound);
    for (int k = 0; k < bound && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      fail_now("drain_timeout");
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_access(input vec_t v);
    sb_t e;
    int  t0;
    bit  got;
    @(negedge clk);
    ack_delay = v.delay;
    mrd_val   = v.mrd;
    req[v.idx]             = 1'b1;
    we_v[v.idx]            = v.we;
    addr_v[v.idx*16 +: 16] = v.addr;
    wdata_v[v.idx*16 +: 16] = v.wdata;
    if (!v.we && !v.exp_err) model_rdata = v.mrd;
    e = '{idx: v.idx, we: v.we, addr: v.addr, wdata: v.wdata,
          rdata: model_rdata, is_err: v.exp_err, lat: v.exp_lat};
    sb.push_back(e);
    t0  = cyc;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (gnt != 0) got = 1;
    end
    if (!got) fail_now("gnt_timeout");
    else chk("gnt_latency", 32'(cyc - t0), 32'd1);
    // Scramble the requester's signals to prove the arbiter latched them.
    req[v.idx]              = 1'b0;
    we_v[v.idx]             = ~v.we;
    addr_v[v.idx*16 +: 16]  = ~v.addr;
    wdata_v[v.idx*16 +: 16] = ~v.wdata;
    drain(40);
  endtask

  vec_t vecs[7];

  initial begin
    logic [15:0] rd_before;
    int          ng;
    bit          got;
    sb_t         e;

    vecs[0] = '{idx: 0, we: 1'b0, addr: 16'h0010, wdata: 16'h0000, delay: 2,   mrd: 16'hBEEF, exp_err: 1'b0, exp_lat: 3};
    vecs[1] = '{idx: 1, we: 1'b1, addr: 16'h0200, wdata: 16'h1234, delay: 0,   mrd: 16'hFFFF, exp_err: 1'b0, exp_lat: 1};
    vecs[2] = '{idx: 2, we: 1'b0, addr: 16'h0300, wdata: 16'h0000, delay: 255, mrd: 16'h5555, exp_err: 1'b1, exp_lat: 4};
    vecs[3] = '{idx: 2, we: 1'b0, addr: 16'h0304, wdata: 16'h0000, delay: 3,   mrd: 16'h4242, exp_err: 1'b0, exp_lat: 4};
    vecs[4] = '{idx: 0, we: 1'b1, addr: 16'hFFFF, wdata: 16'hABCD, delay: 1,   mrd: 16'h9999, exp_err: 1'b0, exp_lat: 2};
    vecs[5] = '{idx: 1, we: 1'b0, addr: 16'h0000, wdata: 16'h0000, delay: 1,   mrd: 16'h0001, exp_err: 1'b0, exp_lat: 2};
    vecs[6] = '{idx: 0, we: 1'b0, addr: 16'h0042, wdata: 16'h0000, delay: 255, mrd: 16'h7E7E, exp_err: 1'b1, exp_lat: 4};

    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_bus", 32'({mem_we, mem_addr, mem_wdata}), 32'd0);
    rst    = 1'b1;
    mon_en = 1'b1;

    // Contention straight after reset: rotation 0,1,2,0,1,2 every 3 cycles.
    @(negedge clk);
    gnt_log.delete();
    ack_delay   = 0;
    mrd_val     = 16'hC0DE;
    model_rdata = 16'hC0DE;
    addr_v      = {16'h0C00, 16'h0B00, 16'h0A00};
    we_v        = 3'b000;
    for (int i = 0; i < 6; i++) begin
      e = '{idx: i % 3, we: 1'b0, addr: 16'h0A00 + 16'(16'h0100 * (i % 3)), wdata: 16'h0,
            rdata: 16'hC0DE, is_err: 1'b0, lat: 1};
      sb.push_back(e);
    end
    req = 3'b111;
    ng  = 0;
    for (int k = 0; k < 60 && ng < 6; k++) begin
      @(negedge clk);
      if (gnt != 0) ng++;
      if (ng == 6) req = 3'b000;
    end
    req = 3'b000;
    chk("contention_grants", 32'(ng), 32'd6);
    drain(20);
    if (gnt_log.size() == 6) begin
      for (int i = 1; i < 6; i++) chk("contention_spacing", 32'(gnt_log[i] - gnt_log[i-1]), 32'd3);
    end else fail_now("contention_log_size");

    foreach (vecs[i]) do_access(vecs[i]);

    // Stray ack while idle must not disturb anything.
    rd_before = rdata;
    @(negedge clk);
    mrd_val = 16'h7777;
    stray   = 1'b1;
    repeat (2) @(negedge clk);
    stray = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("stray_outputs", 32'({gnt, done, err, mem_req}), 32'd0);
      chk("stray_rdata", 32'(rdata), 32'(rd_before));
    end
    do_access(vecs[0]);

    // Reset in the second BUSY cycle drops the access silently.
    @(negedge clk);
    ack_delay = 255;
    addr_v[15:0] = 16'h0123;
    we_v[0] = 1'b0;
    e = '{idx: 0, we: 1'b0, addr: 16'h0123, wdata: 16'h0, rdata: 16'h0, is_err: 1'b0, lat: 1};
    sb.push_back(e);
    req[0] = 1'b1;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (gnt != 0) got = 1;
    end
    if (!got) fail_now("rstmid_gnt_timeout");
    req[0] = 1'b0;
    @(negedge clk);
    sb.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_mem_req", 32'(mem_req), 32'd0);
    chk("rstmid_pulses", 32'({gnt, done, err}), 32'd0);
    chk("rstmid_rdata", 32'(rdata), 32'd0);
    rst         = 1'b1;
    ack_delay   = 0;
    mrd_val     = 16'h3C3C;
    model_rdata = 16'h3C3C;
    addr_v      = {16'h0E00, 16'h0D00, 16'h0000};
    we_v        = 3'b000;
    e = '{idx: 1, we: 1'b0, addr: 16'h0D00, wdata: 16'h0, rdata: 16'h3C3C, is_err: 1'b0, lat: 1};
    sb.push_back(e);
    e = '{idx: 2, we: 1'b0, addr: 16'h0E00, wdata: 16'h0, rdata: 16'h3C3C, is_err: 1'b0, lat: 1};
    sb.push_back(e);
    req = 3'b110;
    for (int k = 0; k < 20 && req != 0; k++) begin
      @(negedge clk);
      req = req & ~gnt;
    end
    req = 3'b000;
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "bench did not complete");
  end

endmodule
